tmds_pattern_gen: RTL and testbench

Multi-channel TMDS compliance/test pattern source. It feeds one 10-bit symbol stream per TMDS lane into the symbol FIFOs of the `tmds` serializer instances. It generalises the single-lane free-running LFSR hookup to selectable patterns, an independent flow-controlled lane per channel, and a start/stop/burst-length run control for bench and scope work.

---
 rtl/tmds_pattern_pkg.sv | 56 +++++
 rtl/tmds_pattern_lane.sv | 96 +++++++++
 rtl/tmds_pattern_gen.sv | 105 ++++++++++
 tb/tb_tmds_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pattern_pkg.sv
// Shared constants, types and the PRBS15 symbol helper for the TMDS pattern source.
package tmds_pattern_pkg;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [1:0] ModePrbs  = 2'd0;
    localparam logic [1:0] ModeClock = 2'd1;
    localparam logic [1:0] ModeCtrl  = 2'd2;
    localparam logic [1:0] ModeRamp  = 2'd3;

    localparam int unsigned PatWidth = 10;

    localparam logic [PatWidth-1:0] ClockSym = 10'b0000011111;
    localparam logic [PatWidth-1:0] CtrlSym0 = 10'b1101010100;
    localparam logic [PatWidth-1:0] CtrlSym1 = 10'b0010101011;
    localparam logic [PatWidth-1:0] CtrlSym2 = 10'b0101010100;
    localparam logic [PatWidth-1:0] CtrlSym3 = 10'b1010101011;

    // x^15 + x^14 + 1, Fibonacci form, shifting left
    localparam int unsigned PrbsWidth = 15;
    localparam int unsigned PrbsTapHi = 14;
    localparam int unsigned PrbsTapLo = 13;

    typedef struct packed {
        logic [PrbsWidth-1:0] state;
        logic [PatWidth-1:0]  sym;
    } prbs_step_t;

    // Runs PatWidth LFSR steps; feedback of step k lands in symbol bit k.
    function automatic prbs_step_t prbs15_advance(input logic [PrbsWidth-1:0] seed);
        prbs_step_t res;
        logic [PrbsWidth-1:0] s;
        logic f;
        s = seed;
        res.sym = '0;
        for (int k = 0; k < PatWidth; k++) begin
            f = s[PrbsTapHi] ^ s[PrbsTapLo];
            res.sym[k] = f;
            s = {s[PrbsWidth-2:0], f};
        end
        res.state = s;
        return res;
    endfunction

    function automatic logic [PatWidth-1:0] ctrl_symbol(input logic [1:0] idx);
        logic [PatWidth-1:0] sym;
        case (idx)
            2'd0:    sym = CtrlSym0;
            2'd1:    sym = CtrlSym1;
            2'd2:    sym = CtrlSym2;
            default: sym = CtrlSym3;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/tmds_pattern_lane.sv
// One flow-controlled pattern lane: generators, pattern mux, symbol counter and done flag.
// Optional one-shot bit-0 corruption when TMDS_PATTERN_ERR_INJECT_EN is defined.
module tmds_pattern_lane
    import tmds_pattern_pkg::*;
#(
    parameter int unsigned          SYMBOL_WIDTH = 10,
    parameter int unsigned          LEN_WIDTH    = 32,
    parameter logic [PrbsWidth-1:0] LANE_SEED    = 15'h0001
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic                    busy_i,
    input  logic                    stop_i,
    input  logic                    fifo_full_i,
`ifdef TMDS_PATTERN_ERR_INJECT_EN
    input  logic                    inject_i,
`endif
    input  logic [1:0]              mode_i,
    input  logic [LEN_WIDTH-1:0]    length_i,
    output logic                    write_symbol_o,
    output logic [SYMBOL_WIDTH-1:0] symbol_o,
    output logic                    done_next_o
);

    logic [PrbsWidth-1:0]    lfsr_q;
    logic [SYMBOL_WIDTH-1:0] ramp_q;
    logic [1:0]              ctrl_idx_q;
    logic [LEN_WIDTH-1:0]    cnt_q;
    logic [LEN_WIDTH-1:0]    cnt_inc;
    logic                    len_limited;
    logic                    lane_done;
    logic                    write;
    logic                    flip;
    prbs_step_t              prbs;
    logic [SYMBOL_WIDTH-1:0] gen_sym;

    assign prbs        = prbs15_advance(lfsr_q);
    assign cnt_inc     = cnt_q + LEN_WIDTH'(1);
    assign len_limited = (length_i != '0);
    assign lane_done   = len_limited && (cnt_q == length_i);
    assign write       = busy_i && !fifo_full_i && !lane_done && !stop_i;

    // Lets the shared FSM leave RUN in the same cycle as the final write of the slowest lane.
    assign done_next_o = len_limited && (lane_done || (write && (cnt_inc == length_i)));

    always_comb begin
        gen_sym = '0;
        case (mode_i)
            ModePrbs:  gen_sym = SYMBOL_WIDTH'(prbs.sym);
            ModeClock: gen_sym = SYMBOL_WIDTH'(ClockSym);
            ModeCtrl:  gen_sym = SYMBOL_WIDTH'(ctrl_symbol(ctrl_idx_q));
            default:   gen_sym = ramp_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q     <= LANE_SEED;
            ramp_q     <= '0;
            ctrl_idx_q <= '0;
            cnt_q      <= '0;
        end else if (load_i) begin
            lfsr_q     <= LANE_SEED;
            ramp_q     <= '0;
            ctrl_idx_q <= '0;
            cnt_q      <= '0;
        end else if (write) begin
            lfsr_q     <= prbs.state;
            ramp_q     <= ramp_q + SYMBOL_WIDTH'(1);
            ctrl_idx_q <= ctrl_idx_q + 2'd1;
            cnt_q      <= cnt_inc;
        end
    end

`ifdef TMDS_PATTERN_ERR_INJECT_EN
    logic inject_q;

    // Arm survives IDLE and restarts; only a write consumes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inject_q <= 1'b0;
        end else begin
            inject_q <= inject_i || (inject_q && !write);
        end
    end

    assign flip = inject_q;
`else
    assign flip = 1'b0;
`endif

    assign write_symbol_o = write;
    assign symbol_o       = busy_i ? (gen_sym ^ {{(SYMBOL_WIDTH-1){1'b0}}, flip}) : '0;

endmodule

// File: rtl/tmds_pattern_gen.sv
// Multi-lane TMDS test pattern source with start/stop/burst run control.
// Define TMDS_PATTERN_ERR_INJECT_EN to add the per-lane inject_i error-injection port.
module tmds_pattern_gen
    import tmds_pattern_pkg::*;
#(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned SYMBOL_WIDTH = 10,
    parameter int unsigned LEN_WIDTH    = 32,
    parameter int unsigned SEED         = 15'h0001
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             stop_i,
    input  logic [1:0]                       mode_i,
    input  logic [LEN_WIDTH-1:0]             length_i,
    input  logic [CHANNELS-1:0]              fifo_full_i,
`ifdef TMDS_PATTERN_ERR_INJECT_EN
    input  logic [CHANNELS-1:0]              inject_i,
`endif
    output logic [CHANNELS-1:0]              write_symbol_o,
    output logic [CHANNELS*SYMBOL_WIDTH-1:0] symbol_o,
    output logic                             busy_o,
    output logic                             done_o
);

    if (CHANNELS < 1 || CHANNELS > 8 || SEED == 0 ||
        (SEED + CHANNELS - 1) > 32'h7FFF) begin : gen_param_err
        $error("tmds_pattern_gen: CHANNELS must be 1..8 and SEED+lane nonzero within 15 bits");
    end

    state_e               state_q, state_d;
    logic [1:0]           mode_q;
    logic [LEN_WIDTH-1:0] length_q;
    logic                 done_q, done_d;
    logic                 busy;
    logic                 load;
    logic [CHANNELS-1:0]  lane_done_next;

    assign busy = (state_q == StRun);
    assign load = (state_q == StIdle) && start_i && !stop_i;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StRun;
                end
            end
            default: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if ((length_q != '0) && (&lane_done_next)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            mode_q   <= ModePrbs;
            length_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                mode_q   <= mode_i;
                length_q <= length_i;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : gen_lane
        tmds_pattern_lane #(
            .SYMBOL_WIDTH (SYMBOL_WIDTH),
            .LEN_WIDTH    (LEN_WIDTH),
            .LANE_SEED    (PrbsWidth'(SEED + c))
        ) u_lane (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .load_i         (load),
            .busy_i         (busy),
            .stop_i         (stop_i),
            .fifo_full_i    (fifo_full_i[c]),
`ifdef TMDS_PATTERN_ERR_INJECT_EN
            .inject_i       (inject_i[c]),
`endif
            .mode_i         (mode_q),
            .length_i       (length_q),
            .write_symbol_o (write_symbol_o[c]),
            .symbol_o       (symbol_o[c*SYMBOL_WIDTH +: SYMBOL_WIDTH]),
            .done_next_o    (lane_done_next[c])
        );
    end

    assign busy_o = busy;
    assign done_o = done_q;

endmodule

// File: tb/tb_tmds_pattern_gen.sv
// Self-checking bench for tmds_pattern_gen: table of runs plus hand-written corner sequences,
// checked every cycle against a behavioural lane/run model.
module tb_tmds_pattern_gen;

    localparam int unsigned CH   = 3;
    localparam int unsigned SW   = 10;
    localparam int unsigned LW   = 32;
    localparam int unsigned SEED = 1;
    localparam int unsigned MAXJ = 512;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              stop_i;
    logic [1:0]        mode_i;
    logic [LW-1:0]     length_i;
    logic [CH-1:0]     fifo_full_i;
    logic [CH-1:0]     write_symbol_o;
    logic [CH*SW-1:0]  symbol_o;
    logic              busy_o;
    logic              done_o;
`ifdef TMDS_PATTERN_ERR_INJECT_EN
    logic [CH-1:0]     inject_i;
`endif

    tmds_pattern_gen #(
        .CHANNELS     (CH),
        .SYMBOL_WIDTH (SW),
        .LEN_WIDTH    (LW),
        .SEED         (SEED)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .mode_i         (mode_i),
        .length_i       (length_i),
        .fifo_full_i    (fifo_full_i),
`ifdef TMDS_PATTERN_ERR_INJECT_EN
        .inject_i       (inject_i),
`endif
        .write_symbol_o (write_symbol_o),
        .symbol_o       (symbol_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference PRBS bit streams: bits 0..14 are the seed oldest-first, then the recurrence.
    bit       prbs_bits [CH][15 + 10*MAXJ];
    bit [9:0] ctrl_tab  [4];

    function automatic bit [9:0] exp_sym(input int c, input bit [1:0] m, input int unsigned j);
        bit [9:0] s;
        s = '0;
        case (m)
            2'd0: for (int k = 0; k < 10; k++) s[k] = prbs_bits[c][15 + 10*(j % MAXJ) + k];
            2'd1: s = 10'b0000011111;
            2'd2: s = ctrl_tab[j % 4];
            default: s = 10'(j % 1024);
        endcase
        return s;
    endfunction

    // Behavioural model state, advanced once per cycle by the monitor.
    bit          mon_en = 1'b0;
    bit          m_busy, m_done;
    bit [1:0]    m_mode;
    int unsigned m_len;
    int unsigned wr_cnt [CH];
    bit          pend   [CH];
    int          flips = 0;
    int          done_seen = 0;

    always @(negedge clk_i) begin
        if (mon_en) begin
            bit all_done;
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("done", 32'(done_o), 32'(m_done));
            if (done_o) done_seen++;
            for (int c = 0; c < CH; c++) begin
                bit       exp_wr;
                bit [9:0] got, exp;
                exp_wr = m_busy && !fifo_full_i[c] && !stop_i &&
                         !(m_len != 0 && wr_cnt[c] == m_len);
                chk($sformatf("write[%0d]", c), 32'(write_symbol_o[c]), 32'(exp_wr));
                got = symbol_o[c*SW +: SW];
                if (!m_busy) begin
                    chk($sformatf("idle_sym[%0d]", c), 32'(got), 0);
                end else if (write_symbol_o[c]) begin
                    exp = exp_sym(c, m_mode, wr_cnt[c]);
                    if (pend[c]) begin
                        exp[0] = ~exp[0];
                        flips++;
                        pend[c] = 1'b0;
                    end
                    chk($sformatf("sym[%0d]#%0d", c, wr_cnt[c]), 32'(got), 32'(exp));
                    wr_cnt[c]++;
                end
`ifdef TMDS_PATTERN_ERR_INJECT_EN
                if (inject_i[c]) pend[c] = 1'b1;
`endif
            end
            all_done = (m_len != 0);
            for (int c = 0; c < CH; c++) if (wr_cnt[c] != m_len) all_done = 1'b0;
            m_done = 1'b0;
            if (!m_busy) begin
                if (start_i && !stop_i) begin
                    m_busy = 1'b1;
                    m_mode = mode_i;
                    m_len  = length_i;
                    for (int c = 0; c < CH; c++) wr_cnt[c] = 0;
                end
            end else if (stop_i) begin
                m_busy = 1'b0;
            end else if (all_done) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    typedef struct {
        bit [1:0]    mode;
        int unsigned len;
        bit [CH-1:0] bp;
        int unsigned cycles;
        int          inj_at;
    } run_t;

    task automatic run_case(input run_t r);
        int n, d0, f0;
        d0 = done_seen;
        f0 = flips;
        mode_i   = r.mode;
        length_i = r.len;
        start_i  = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n = 0;
        while (busy_o && n < 6000) begin
            fifo_full_i = CH'($urandom) & r.bp;
            if (r.len == 0 && n == int'(r.cycles)) stop_i = 1'b1;
`ifdef TMDS_PATTERN_ERR_INJECT_EN
            if (n == r.inj_at) inject_i[0] = 1'b1;
`endif
            @(posedge clk_i); #1;
            stop_i      = 1'b0;
            fifo_full_i = '0;
`ifdef TMDS_PATTERN_ERR_INJECT_EN
            inject_i = '0;
`endif
            n++;
        end
        chk("run_timeout", 32'(n >= 6000), 0);
        @(posedge clk_i); #1;
        for (int c = 0; c < CH; c++)
            chk($sformatf("count[%0d]", c), wr_cnt[c], (r.len != 0) ? r.len : r.cycles);
        chk("done_pulses", 32'(done_seen - d0), 32'(r.len != 0));
        chk("busy_after", 32'(busy_o), 0);
`ifdef TMDS_PATTERN_ERR_INJECT_EN
        if (r.inj_at >= 0) chk("inject_flips", 32'(flips - f0), 1);
`else
        chk("no_flips", 32'(flips - f0), 0);
`endif
    endtask

    run_t runs [7];

    initial begin
        ctrl_tab[0] = 10'b1101010100;
        ctrl_tab[1] = 10'b0010101011;
        ctrl_tab[2] = 10'b0101010100;
        ctrl_tab[3] = 10'b1010101011;
        for (int c = 0; c < CH; c++) begin
            bit [14:0] s;
            s = 15'(SEED + c);
            for (int i = 0; i < 15; i++) prbs_bits[c][i] = s[14-i];
            for (int i = 15; i < 15 + 10*MAXJ; i++)
                prbs_bits[c][i] = prbs_bits[c][i-15] ^ prbs_bits[c][i-14];
        end
        for (int c = 0; c < CH; c++) begin
            wr_cnt[c] = 0;
            pend[c]   = 1'b0;
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        m_mode = 2'd0;
        m_len  = 0;

        //          mode  len   bp      cycles inj_at
        runs[0] = '{2'd3, 0,    3'b000, 1100,  -1};
        runs[1] = '{2'd1, 5,    3'b000, 0,     -1};
        runs[2] = '{2'd0, 400,  3'b010, 0,     -1};
        runs[3] = '{2'd0, 200,  3'b111, 0,     -1};
        runs[4] = '{2'd2, 0,    3'b000, 6,     -1};
        runs[5] = '{2'd2, 9,    3'b101, 0,     -1};
        runs[6] = '{2'd3, 1,    3'b000, 0,     -1};

        rst_i = 1'b1;
        start_i = 1'b0;
        stop_i = 1'b0;
        mode_i = '0;
        length_i = '0;
        fifo_full_i = '0;
`ifdef TMDS_PATTERN_ERR_INJECT_EN
        inject_i = '0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_write", 32'(write_symbol_o), 0);
        chk("rst_symbol", 32'(symbol_o), 0);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 7; i++) run_case(runs[i]);

        // Simultaneous start and stop in IDLE must not start a run.
        mode_i = 2'd3; length_i = 4; start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; stop_i = 1'b0;
        chk("startstop_busy", 32'(busy_o), 0);
        @(posedge clk_i); #1;

        // Mid-run start is ignored; async reset clears outputs without a clock edge.
        mode_i = 2'd3; length_i = 0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) begin @(posedge clk_i); #1; end
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
        chk("prereset_progress", wr_cnt[0], 6);
        mon_en = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("async_busy", 32'(busy_o), 0);
        chk("async_write", 32'(write_symbol_o), 0);
        chk("async_symbol", 32'(symbol_o), 0);
        @(posedge clk_i); #1;
        rst_i  = 1'b0;
        m_busy = 1'b0;
        m_done = 1'b0;
        for (int c = 0; c < CH; c++) pend[c] = 1'b0;
        mon_en = 1'b1;
        @(posedge clk_i); #1;
        run_case('{2'd3, 8, 3'b000, 0, -1});

`ifdef TMDS_PATTERN_ERR_INJECT_EN
        // Arm lane 0 while idle; the first symbol of the next run carries the flip.
        inject_i[0] = 1'b1;
        @(posedge clk_i); #1;
        inject_i = '0;
        run_case('{2'd3, 4, 3'b000, 0, 100});
        run_case('{2'd3, 20, 3'b000, 0, 10});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
